// File: rtl/lmi_dbus_node_if.sv
// Bus bundle for lmi_dbus_node: client request/grant handshake, burst data and the
// shared pass-through/downstream data path.
interface lmi_dbus_node_if #(
    parameter int unsigned DW  = 32,
    parameter int unsigned NCH = 2,
    parameter int unsigned LW  = 3
);
    logic                SEN;
    logic                HALT;
    logic [NCH-1:0]      REQ;
    logic [NCH*LW-1:0]   CH_LEN;
    logic [NCH*DW-1:0]   CH_DATA;
    logic [NCH-1:0]      GNT;
    logic                BEAT;
    logic                LAST;
    logic [DW-1:0]       THRU;
    logic [DW-1:0]       OUT;
    logic                OE;

    // Driver side: local clients, upstream bus and pipeline/scan control
    modport master (
        output SEN, HALT, REQ, CH_LEN, CH_DATA, THRU,
        input  GNT, BEAT, LAST, OUT, OE
    );

    // Node side
    modport slave (
        input  SEN, HALT, REQ, CH_LEN, CH_DATA, THRU,
        output GNT, BEAT, LAST, OUT, OE
    );
endinterface

// File: rtl/lmi_dbus_node.sv
// Round-robin arbitrated data-bus node: a granted local client bursts onto the shared
// bus in place of pass-through data. Define LMI_DBUS_PIPE_EN to register OUT/OE.
module lmi_dbus_node #(
    parameter int unsigned DW       = 32,
    parameter int unsigned NCH      = 2,
    parameter int unsigned MAXBURST = 8,
    parameter int unsigned LW       = $clog2(MAXBURST)
) (
    input  logic              CLK,
    input  logic              RESET_D1_R,
    lmi_dbus_node_if.slave    bus
);
    localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]     state_q, state_d;
    logic [NCH-1:0] gnt_q,   gnt_d;
    logic [PW-1:0]  idx_q,   idx_d;
    logic [PW-1:0]  ptr_q,   ptr_d;
    logic [LW-1:0]  cnt_q,   cnt_d;

    logic [PW-1:0]  sel_c;
    logic [PW-1:0]  cand_c;
    logic           found_c;
    logic           beat_c;
    logic           last_c;
    logic           drive_c;
    logic [DW-1:0]  data_c;

    // First requester at or after ptr, wrapping NCH-1 -> 0
    always_comb begin
        sel_c   = ptr_q;
        cand_c  = ptr_q;
        found_c = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            cand_c = PW'((32'(ptr_q) + i) % NCH);
            if (!found_c && bus.REQ[cand_c]) begin
                found_c = 1'b1;
                sel_c   = cand_c;
            end
        end
    end

    assign beat_c  = (state_q == ST_BURST) && !bus.HALT && !bus.SEN;
    assign last_c  = beat_c && (cnt_q == '0);
    assign drive_c = (state_q == ST_BURST) && !bus.SEN;
    assign data_c  = bus.CH_DATA[32'(idx_q)*DW +: DW];

    // Next-state logic; SEN freezes everything by leaving the defaults in place
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (!bus.SEN) begin
            case (state_q)
                ST_IDLE: begin
                    if (found_c) begin
                        state_d = ST_BURST;
                        gnt_d   = NCH'(1) << sel_c;
                        idx_d   = sel_c;
                        cnt_d   = bus.CH_LEN[32'(sel_c)*LW +: LW];
                    end
                end
                ST_BURST: begin
                    if (last_c) begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        ptr_d   = (idx_q == PW'(NCH-1)) ? '0 : idx_q + PW'(1);
                    end else if (beat_c) begin
                        cnt_d   = cnt_q - LW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET_D1_R) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.GNT  = gnt_q;
    assign bus.BEAT = beat_c;
    assign bus.LAST = last_c;

`ifdef LMI_DBUS_PIPE_EN
    logic          oe_q,  oe_d;
    logic [DW-1:0] out_q, out_d;

    // Output stage holds through HALT and SEN; SEN bypasses it to THRU
    always_comb begin
        oe_d  = oe_q;
        out_d = out_q;
        if (!bus.SEN && !bus.HALT) begin
            oe_d  = drive_c;
            out_d = drive_c ? data_c : bus.THRU;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET_D1_R) begin
            oe_q  <= 1'b0;
            out_q <= '0;
        end else begin
            oe_q  <= oe_d;
            out_q <= out_d;
        end
    end

    assign bus.OE  = oe_q && !bus.SEN;
    assign bus.OUT = bus.SEN ? bus.THRU : out_q;
`else
    assign bus.OE  = drive_c;
    assign bus.OUT = drive_c ? data_c : bus.THRU;
`endif
endmodule

// File: tb/tb_lmi_dbus_node.sv
// Directed bench for lmi_dbus_node (NCH=2, DW=32, MAXBURST=8).
module tb_lmi_dbus_node;
`ifdef LMI_DBUS_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    lmi_dbus_node_if #(.DW(32), .NCH(2), .LW(3)) bus ();

    lmi_dbus_node #(.DW(32), .NCH(2), .MAXBURST(8)) dut (
        .CLK        (clk),
        .RESET_D1_R (rst),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.REQ  = '0;
        bus.HALT = 1'b0;
        bus.SEN  = 1'b0;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] ctl;
        rst      = 1'b1;
        bus.THRU = 32'hCAFE_0001;
        bus.REQ  = 2'b11;
        next_cycle();
        next_cycle();
        #1;
        ctl = {bus.GNT, bus.OE, bus.BEAT, bus.LAST};
        checks++;
        if (ctl !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctl got=%b exp=%b", ctl, 5'b0);
        end
        checks++;
        if (bus.OUT !== (PIPE ? 32'h0 : 32'hCAFE_0001)) begin
            failures++;
            $display("FAIL reset_out got=%h exp=%h", bus.OUT, PIPE ? 32'h0 : 32'hCAFE_0001);
        end
        rst     = 1'b0;
        bus.REQ = '0;
        next_cycle();
    endtask

    // Client 0, 4-beat burst stepping A0..A3
    task automatic test_single();
        logic [4:0] ctl, exp_ctl;
        do_reset();
        bus.THRU          = 32'h1234_5678;
        bus.REQ           = 2'b01;
        bus.CH_LEN[2:0]   = 3'd3;
        bus.CH_DATA[31:0] = 32'hA0;
        #1;
        ctl = {bus.GNT, bus.OE, bus.BEAT, bus.LAST};
        checks++;
        if (ctl !== 5'b0 || bus.OUT !== 32'h1234_5678) begin
            failures++;
            $display("FAIL single_idle ctl=%b out=%h exp_ctl=00000 exp_out=12345678", ctl, bus.OUT);
        end
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            bus.REQ           = 2'b00;
            bus.CH_DATA[31:0] = 32'hA0 + 32'(k - 1);
            #1;
            ctl     = {bus.GNT, bus.OE, bus.BEAT, bus.LAST};
            exp_ctl = {2'b01, 1'b1, 1'b1, (k == 4)};
            checks++;
            if (ctl !== exp_ctl) begin
                failures++;
                $display("FAIL single_ctl beat=%0d got=%b exp=%b", k, ctl, exp_ctl);
            end
            checks++;
            if (bus.OUT !== 32'hA0 + 32'(k - 1)) begin
                failures++;
                $display("FAIL single_out beat=%0d got=%h exp=%h", k, bus.OUT, 32'hA0 + 32'(k - 1));
            end
        end
        next_cycle();
        #1;
        ctl = {bus.GNT, bus.OE, bus.BEAT, bus.LAST};
        checks++;
        if (ctl !== 5'b0 || bus.OUT !== 32'h1234_5678) begin
            failures++;
            $display("FAIL single_after ctl=%b out=%h exp_ctl=00000 exp_out=12345678", ctl, bus.OUT);
        end
    endtask

    // Both clients requesting, single-beat bursts
    task automatic test_round_robin();
        logic [1:0]  exp_gnt [1:5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        logic [4:0]  ctl, exp_ctl;
        logic [31:0] exp_out;
        do_reset();
        bus.THRU           = 32'h7777_0000;
        bus.REQ            = 2'b11;
        bus.CH_LEN         = '0;
        bus.CH_DATA[31:0]  = 32'hD000_0000;
        bus.CH_DATA[63:32] = 32'hD111_1111;
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            #1;
            ctl     = {bus.GNT, bus.OE, bus.BEAT, bus.LAST};
            exp_ctl = {exp_gnt[c], |exp_gnt[c], |exp_gnt[c], |exp_gnt[c]};
            exp_out = (exp_gnt[c] == 2'b01) ? 32'hD000_0000 :
                      (exp_gnt[c] == 2'b10) ? 32'hD111_1111 : 32'h7777_0000;
            checks++;
            if (ctl !== exp_ctl || bus.OUT !== exp_out) begin
                failures++;
                $display("FAIL rr cyc=%0d ctl=%b out=%h exp_ctl=%b exp_out=%h",
                         c, ctl, bus.OUT, exp_ctl, exp_out);
            end
        end
        bus.REQ = 2'b00;
        next_cycle();
        #1;
        checks++;
        if (bus.GNT !== 2'b00) begin
            failures++;
            $display("FAIL rr_end gnt got=%b exp=00", bus.GNT);
        end
    endtask

    // HALT for two cycles after the second beat
    task automatic test_halt();
        logic       halt_v [1:6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [4:0] ctl, exp_ctl;
        int         nb = 0;
        int         dut_beats = 0;
        logic       eb;
        do_reset();
        bus.THRU        = 32'h0BAD_F00D;
        bus.REQ         = 2'b01;
        bus.CH_LEN[2:0] = 3'd3;
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            bus.REQ           = 2'b00;
            bus.HALT          = halt_v[c];
            bus.CH_DATA[31:0] = 32'hB0 + 32'(nb);
            #1;
            eb      = !halt_v[c];
            exp_ctl = {2'b01, 1'b1, eb, eb && (nb == 3)};
            ctl     = {bus.GNT, bus.OE, bus.BEAT, bus.LAST};
            dut_beats += int'(bus.BEAT);
            checks++;
            if (ctl !== exp_ctl || bus.OUT !== 32'hB0 + 32'(nb)) begin
                failures++;
                $display("FAIL halt cyc=%0d ctl=%b out=%h exp_ctl=%b exp_out=%h",
                         c, ctl, bus.OUT, exp_ctl, 32'hB0 + 32'(nb));
            end
            if (eb) nb++;
        end
        bus.HALT = 1'b0;
        next_cycle();
        #1;
        checks++;
        if (bus.GNT !== 2'b00 || bus.OE !== 1'b0) begin
            failures++;
            $display("FAIL halt_end gnt=%b oe=%b exp 00/0", bus.GNT, bus.OE);
        end
        checks++;
        if (dut_beats != 4) begin
            failures++;
            $display("FAIL halt_beats got=%0d exp=4", dut_beats);
        end
    endtask

    // SEN for three cycles after beat 1
    task automatic test_sen();
        logic        sen_v [1:7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [4:0]  ctl, exp_ctl;
        logic [31:0] exp_out;
        int          nb = 0;
        int          lasts = 0;
        logic        eb;
        do_reset();
        bus.THRU        = 32'h5555_5555;
        bus.REQ         = 2'b01;
        bus.CH_LEN[2:0] = 3'd3;
        for (int c = 1; c <= 7; c++) begin
            next_cycle();
            bus.REQ           = 2'b00;
            bus.SEN           = sen_v[c];
            bus.CH_DATA[31:0] = 32'hC0 + 32'(nb);
            #1;
            eb      = !sen_v[c];
            exp_ctl = {2'b01, !sen_v[c], eb, eb && (nb == 3)};
            exp_out = sen_v[c] ? 32'h5555_5555 : 32'hC0 + 32'(nb);
            ctl     = {bus.GNT, bus.OE, bus.BEAT, bus.LAST};
            lasts  += int'(bus.LAST);
            checks++;
            if (ctl !== exp_ctl || bus.OUT !== exp_out) begin
                failures++;
                $display("FAIL sen cyc=%0d ctl=%b out=%h exp_ctl=%b exp_out=%h",
                         c, ctl, bus.OUT, exp_ctl, exp_out);
            end
            if (eb) nb++;
        end
        next_cycle();
        #1;
        checks++;
        if (bus.GNT !== 2'b00) begin
            failures++;
            $display("FAIL sen_end gnt got=%b exp=00", bus.GNT);
        end
        checks++;
        if (lasts != 1) begin
            failures++;
            $display("FAIL sen_lasts got=%0d exp=1", lasts);
        end
    endtask

    // Reset during client 1 burst; pointer must return to client 0
    task automatic test_reset_mid();
        logic [4:0] ctl;
        do_reset();
        bus.THRU           = 32'h9999_0000;
        bus.REQ            = 2'b01;
        bus.CH_LEN[2:0]    = 3'd0;
        bus.CH_LEN[5:3]    = 3'd3;
        bus.CH_DATA[31:0]  = 32'hE000_0000;
        bus.CH_DATA[63:32] = 32'hE111_1111;
        next_cycle();
        bus.REQ = 2'b10;
        #1;
        ctl = {bus.GNT, bus.OE, bus.BEAT, bus.LAST};
        checks++;
        if (ctl !== 5'b01111) begin
            failures++;
            $display("FAIL rmid_c0 ctl got=%b exp=01111", ctl);
        end
        next_cycle();
        next_cycle();
        #1;
        ctl = {bus.GNT, bus.OE, bus.BEAT, bus.LAST};
        checks++;
        if (ctl !== 5'b10110 || bus.OUT !== 32'hE111_1111) begin
            failures++;
            $display("FAIL rmid_c1 ctl=%b out=%h exp_ctl=10110 exp_out=e1111111", ctl, bus.OUT);
        end
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst     = 1'b0;
        bus.REQ = 2'b11;
        #1;
        ctl = {bus.GNT, bus.OE, bus.BEAT, bus.LAST};
        checks++;
        if (ctl !== 5'b0 || bus.OUT !== 32'h9999_0000) begin
            failures++;
            $display("FAIL rmid_after ctl=%b out=%h exp_ctl=00000 exp_out=99990000", ctl, bus.OUT);
        end
        next_cycle();
        #1;
        checks++;
        if (bus.GNT !== 2'b01) begin
            failures++;
            $display("FAIL rmid_regrant gnt got=%b exp=01", bus.GNT);
        end
        bus.REQ = 2'b00;
        next_cycle();
        next_cycle();
        next_cycle();
        next_cycle();
    endtask

`ifdef LMI_DBUS_PIPE_EN
    // Registered output stage: OUT/OE trail BEAT/GNT by one cycle
    task automatic test_pipe();
        logic        exp_oe;
        logic [31:0] exp_out;
        do_reset();
        bus.THRU          = 32'h1234_5678;
        bus.REQ           = 2'b01;
        bus.CH_LEN[2:0]   = 3'd3;
        bus.CH_DATA[31:0] = 32'hA0;
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            bus.REQ = 2'b00;
            if (c <= 4) bus.CH_DATA[31:0] = 32'hA0 + 32'(c - 1);
            #1;
            exp_oe  = (c >= 2) && (c <= 5);
            exp_out = exp_oe ? 32'hA0 + 32'(c - 2) : 32'h1234_5678;
            checks++;
            if (bus.OE !== exp_oe || bus.OUT !== exp_out || bus.GNT !== ((c <= 4) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("FAIL pipe cyc=%0d gnt=%b oe=%b out=%h exp_oe=%b exp_out=%h",
                         c, bus.GNT, bus.OE, bus.OUT, exp_oe, exp_out);
            end
        end
    endtask
`endif

    initial begin
        bus.SEN     = 1'b0;
        bus.HALT    = 1'b0;
        bus.REQ     = '0;
        bus.CH_LEN  = '0;
        bus.CH_DATA = '0;
        bus.THRU    = '0;
        test_reset();
`ifdef LMI_DBUS_PIPE_EN
        test_pipe();
`else
        test_single();
        test_round_robin();
        test_halt();
        test_sen();
        test_reset_mid();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
